// File: rtl/proc_operand_driver.sv
// -----------------------------------------------------------------------------
// proc_operand_driver
//
// Host-side initiator for the tt_um_processor core. Operand pairs arrive on a
// valid/ready input stream and are buffered in a small FIFO. One pair at a time
// is driven onto the processor's ui_in/uio_in pins, held for LAT cycles, and
// the processor's uo_out is then captured and offered on a valid/ready response
// stream together with the operands that produced it.
//
// Handshake rule (both streams): a transfer happens at a rising edge where
// valid and ready are both high. A source holds valid and its payload stable
// until that edge; ready carries no combinational dependency on valid.
//
// Parameters:
//   DEPTH      operand FIFO entries, power of two, 2..16
//   LAT        edges from operands appearing on the pins to uo_out being
//              sampled, 1..15
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand pair valid
//   in_ready   FIFO has room (decoded from the registered count only)
//   in_a       operand A, ends up on ui_in
//   in_b       operand B, ends up on uio_in
//   ui_in      to processor dedicated inputs
//   uio_in     to processor bidirectional inputs
//   uo_out     from processor outputs
//   res_valid  result available
//   res_ready  consumer accepts result
//   res_data   captured uo_out
//   res_a      operand A echo
//   res_b      operand B echo
//   busy       high while a transaction is in flight or the FIFO holds pairs
//   done_count completed transactions, 8-bit wrapping
//   state_dbg  current FSM state (IDLE=0, DRIVE=1, RESP=2) for observation
// -----------------------------------------------------------------------------
module proc_operand_driver #(
    parameter int DEPTH = 4,
    parameter int LAT   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    output logic [7:0] ui_in,
    output logic [7:0] uio_in,
    input  logic [7:0] uo_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [7:0] res_a,
    output logic [7:0] res_b,
    output logic       busy,
    output logic [7:0] done_count,
    output logic [1:0] state_dbg
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [3:0]  LAT_C   = 4'(LAT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    // -------------------------------------------------------------------------
    // Operand FIFO
    // -------------------------------------------------------------------------
    logic [7:0]    mem_a [DEPTH];
    logic [7:0]    mem_b [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic [1:0]    state;
    logic [3:0]    wait_cnt;

    logic          push;
    logic          pop;

    // Room is judged on the registered count alone, so a pop in the same
    // cycle never opens the door early and there is no path from any input.
    assign in_ready = (count < DEPTH_C);
    assign push     = in_valid && in_ready;

    // The FSM only takes a new pair while IDLE. Because count is registered,
    // a pair written into an empty FIFO is not visible here until the next
    // edge.
    assign pop      = (state == S_IDLE) && (count != '0);

    // Storage has no reset: entries are only ever read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    // DEPTH is a power of two, so the natural pointer wrap is modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Transaction FSM
    //
    // IDLE : pins at zero; take the FIFO head when one is present.
    // DRIVE: operands held on the pins while wait_cnt counts down from LAT.
    //        The edge that sees wait_cnt == 1 is LAT edges after the operands
    //        first appeared; that edge samples uo_out and clears the pins.
    // RESP : response held until the consumer takes it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wait_cnt   <= 4'd0;
            ui_in      <= 8'd0;
            uio_in     <= 8'd0;
            res_valid  <= 1'b0;
            res_data   <= 8'd0;
            res_a      <= 8'd0;
            res_b      <= 8'd0;
            done_count <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        ui_in    <= mem_a[rd_ptr];
                        uio_in   <= mem_b[rd_ptr];
                        res_a    <= mem_a[rd_ptr];
                        res_b    <= mem_b[rd_ptr];
                        wait_cnt <= LAT_C;
                        state    <= S_DRIVE;
                    end
                end

                S_DRIVE: begin
                    // "<= 1" rather than "== 1" keeps a corrupted zero count
                    // from wrapping to 15 and stalling the pins for 15 cycles.
                    if (wait_cnt <= 4'd1) begin
                        res_data  <= uo_out;
                        res_valid <= 1'b1;
                        ui_in     <= 8'd0;
                        uio_in    <= 8'd0;
                        wait_cnt  <= 4'd0;
                        state     <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                S_RESP: begin
                    // res_valid is always high in this state, so res_ready
                    // alone marks the handshake edge.
                    if (res_ready) begin
                        res_valid  <= 1'b0;
                        done_count <= done_count + 8'd1;
                        state      <= S_IDLE;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    ui_in     <= 8'd0;
                    uio_in    <= 8'd0;
                    res_valid <= 1'b0;
                    wait_cnt  <= 4'd0;
                end
            endcase
        end
    end

    assign busy      = (state != S_IDLE) || (count != '0);
    assign state_dbg = state;

    // -------------------------------------------------------------------------
    // Invariants
    // -------------------------------------------------------------------------
    a_count_bound : assert property (@(posedge clk) disable iff (rst)
        count <= DEPTH_C);

    a_pins_quiet : assert property (@(posedge clk) disable iff (rst)
        (state != S_DRIVE) |-> (ui_in == 8'd0 && uio_in == 8'd0));

    a_resp_hold : assert property (@(posedge clk) disable iff (rst)
        (state == S_RESP && !res_ready) |=>
        (res_valid && $stable(res_data) && $stable(res_a) && $stable(res_b)));

    a_state_legal : assert property (@(posedge clk) disable iff (rst)
        state != 2'd3);

endmodule

// File: tb/tb_proc_operand_driver.sv
// -----------------------------------------------------------------------------
// tb_proc_operand_driver
//
// Two instances: dut (DEPTH=4, LAT=1) against a one-stage adder processor and
// dut3 (DEPTH=4, LAT=3) against a three-stage adder processor. The processor
// stages advance on the falling edge so the sum of operands that appeared
// after rising edge k is settled on uo_out by rising edge k+LAT.
//
// dut is followed every cycle by a transaction-level model: a queue of
// accepted pairs, the pair currently on the pins with the edge index at which
// its result is due, and the response on offer. Directed scenarios add
// literal expectations that pin the model.
// -----------------------------------------------------------------------------
module tb_proc_operand_driver;

    localparam int DEPTH = 4;
    localparam int LAT1  = 1;
    localparam int LAT3  = 3;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // dut signals
    logic       in_valid, in_ready, res_valid, res_ready, busy;
    logic [7:0] in_a, in_b, ui_in, uio_in, uo_out;
    logic [7:0] res_data, res_a, res_b, done_count;
    logic [1:0] state_dbg;

    // dut3 signals
    logic       in_valid3, in_ready3, res_valid3, res_ready3, busy3;
    logic [7:0] in_a3, in_b3, ui_in3, uio_in3, uo_out3;
    logic [7:0] res_data3, res_a3, res_b3, done_count3;
    logic [1:0] state_dbg3;
    logic [7:0] p3_s1, p3_s2;

    proc_operand_driver #(.DEPTH(DEPTH), .LAT(LAT1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .ui_in(ui_in), .uio_in(uio_in), .uo_out(uo_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_a(res_a), .res_b(res_b),
        .busy(busy), .done_count(done_count), .state_dbg(state_dbg)
    );

    proc_operand_driver #(.DEPTH(DEPTH), .LAT(LAT3)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_a(in_a3), .in_b(in_b3),
        .ui_in(ui_in3), .uio_in(uio_in3), .uo_out(uo_out3),
        .res_valid(res_valid3), .res_ready(res_ready3),
        .res_data(res_data3), .res_a(res_a3), .res_b(res_b3),
        .busy(busy3), .done_count(done_count3), .state_dbg(state_dbg3)
    );

    // Processor models
    always @(negedge clk) uo_out <= ui_in + uio_in;

    always @(negedge clk) begin
        p3_s1   <= ui_in3 + uio_in3;
        p3_s2   <= p3_s1;
        uo_out3 <= p3_s2;
    end

    // -------------------------------------------------------------------------
    // Bookkeeping
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;
    int ncyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // -------------------------------------------------------------------------
    // Transaction model of dut (updated on every rising edge)
    // -------------------------------------------------------------------------
    logic [15:0] m_fifo[$];           // accepted pairs not yet on the pins
    logic [23:0] exp_q[$];            // {a, b, a+b} in acceptance order
    int          m_phase = 0;         // 0 waiting, 1 on pins, 2 result offered
    int          m_edge  = 0;
    int          m_due   = 0;         // edge index where the result is taken
    logic [7:0]  m_ra = 8'd0, m_rb = 8'd0, m_rd = 8'd0, m_done = 8'd0;
    logic        m_room;
    logic [15:0] m_head;

    initial begin
        forever begin
            @(posedge clk);
            m_edge++;
            if (rst) begin
                m_fifo.delete();
                exp_q.delete();
                m_phase = 0;
                m_ra = 8'd0; m_rb = 8'd0; m_rd = 8'd0; m_done = 8'd0;
            end else begin
                m_room = (m_fifo.size() < DEPTH);
                if (m_phase == 0) begin
                    if (m_fifo.size() > 0) begin
                        m_head  = m_fifo.pop_front();
                        m_ra    = m_head[15:8];
                        m_rb    = m_head[7:0];
                        m_due   = m_edge + LAT1;
                        m_phase = 1;
                    end
                end else if (m_phase == 1) begin
                    if (m_edge == m_due) begin
                        m_rd    = m_ra + m_rb;
                        m_phase = 2;
                    end
                end else begin
                    if (res_ready) begin
                        m_done  = m_done + 8'd1;
                        m_phase = 0;
                    end
                end
                if (in_valid && m_room) begin
                    m_fifo.push_back({in_a, in_b});
                    exp_q.push_back({in_a, in_b, 8'(in_a + in_b)});
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Compare process (falling edge) + scoreboards
    // -------------------------------------------------------------------------
    logic [7:0]  exp3_q[$];
    logic [23:0] e;
    logic [7:0]  e3;
    logic        log_en = 1'b0;
    logic [7:0]  res_log[$];
    int          res_cyc[$];

    initial begin
        forever begin
            @(negedge clk);
            ncyc++;
            check("in_ready",   in_ready,   32'(m_fifo.size() < DEPTH));
            check("busy",       busy,       32'(m_phase != 0 || m_fifo.size() > 0));
            check("ui_in",      ui_in,      (m_phase == 1) ? m_ra : 8'd0);
            check("uio_in",     uio_in,     (m_phase == 1) ? m_rb : 8'd0);
            check("res_valid",  res_valid,  32'(m_phase == 2));
            check("res_data",   res_data,   m_rd);
            check("res_a",      res_a,      m_ra);
            check("res_b",      res_b,      m_rb);
            check("done_count", done_count, m_done);

            if (!rst && res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL sb_main: got result %0d, expected none (cycle %0d)", res_data, ncyc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_res_a",    res_a,    e[23:16]);
                    check("sb_res_b",    res_b,    e[15:8]);
                    check("sb_res_data", res_data, e[7:0]);
                end
                if (log_en) begin
                    res_log.push_back(res_data);
                    res_cyc.push_back(ncyc);
                end
            end

            if (!rst && res_valid3 && res_ready3) begin
                if (exp3_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL sb_lat3: got result %0d, expected none (cycle %0d)", res_data3, ncyc);
                end else begin
                    e3 = exp3_q.pop_front();
                    check("sb_lat3_data", res_data3, e3);
                end
            end
        end
    end

    int hs3 = 0;
    always @(posedge clk) begin
        if (rst) hs3 <= 0;
        else if (res_valid3 && res_ready3) hs3 <= hs3 + 1;
    end

    // -------------------------------------------------------------------------
    // Driver tasks (inputs change 1 time unit after the rising edge)
    // -------------------------------------------------------------------------
    task automatic push_main(input logic [7:0] a, input logic [7:0] b);
        logic acc;
        int   t;
        in_valid = 1'b1; in_a = a; in_b = b;
        t = 0;
        do begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1; t++;
        end while (!acc && t < 100);
        if (!acc) check("push_main_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic push3(input logic [7:0] a, input logic [7:0] b);
        logic acc;
        int   t;
        in_valid3 = 1'b1; in_a3 = a; in_b3 = b;
        t = 0;
        do begin
            @(negedge clk); acc = in_ready3;
            @(posedge clk); #1; t++;
        end while (!acc && t < 100);
        if (!acc) check("push3_timeout", 0, 1);
        else exp3_q.push_back(a + b);
        in_valid3 = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int t;
        t = 0;
        do begin @(negedge clk); t++; end while (!res_valid && t < 50);
        check(name, res_valid, 1);
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        do begin @(negedge clk); t++; end while (busy && t < 200);
        check(name, busy, 0);
    endtask

    // -------------------------------------------------------------------------
    // Directed scenarios
    // -------------------------------------------------------------------------
    logic [7:0] s2_exp [6] = '{8'd5, 8'd5, 8'd8, 8'd9, 8'd0, 8'd2};
    logic [7:0] s3_exp [6] = '{8'd5, 8'd5, 8'd4, 8'd8, 8'd10, 8'd12};
    logic [7:0] s4_exp [6] = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66};
    logic [7:0] s2_a   [6] = '{8'd3, 8'd1, 8'd5, 8'd7, 8'd0, 8'd1};
    logic [7:0] s2_b   [6] = '{8'd2, 8'd4, 8'd3, 8'd2, 8'd0, 8'd1};

    initial begin
        int n, t;
        // 1. reset with in_valid asserted
        in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9; res_ready = 1'b0;
        in_valid3 = 1'b0; in_a3 = 8'd0; in_b3 = 8'd0; res_ready3 = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("s1_in_ready",   in_ready,   1);
        check("s1_res_valid",  res_valid,  0);
        check("s1_ui_in",      ui_in,      0);
        check("s1_done_count", done_count, 0);
        repeat (3) @(negedge clk);
        check("s1_nothing_accepted", busy, 0);

        // 2. basic sequence, res_ready high
        @(posedge clk); #1;
        res_ready = 1'b1;
        res_log.delete(); res_cyc.delete(); log_en = 1'b1;
        for (int i = 0; i < 6; i++) push_main(s2_a[i], s2_b[i]);
        wait_idle("s2_drain");
        check("s2_count", res_log.size(), 6);
        if (res_log.size() == 6) begin
            for (int i = 0; i < 6; i++) check("s2_result", res_log[i], s2_exp[i]);
            for (int i = 1; i < 6; i++) check("s2_gap", res_cyc[i] - res_cyc[i-1], 3);
        end
        check("s2_done_count", done_count, 6);

        // 3. backpressure
        @(posedge clk); #1;
        res_ready = 1'b0;
        res_log.delete();
        push_main(3, 2); push_main(1, 4); push_main(2, 2); push_main(4, 4); push_main(5, 5);
        in_valid = 1'b1; in_a = 8'd6; in_b = 8'd6;
        repeat (4) begin
            @(negedge clk);
            check("s3_in_ready_low", in_ready,  0);
            check("s3_hold_valid",   res_valid, 1);
            check("s3_hold_data",    res_data,  5);
            check("s3_hold_a",       res_a,     3);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        push_main(6, 6);
        wait_idle("s3_drain");
        check("s3_count", res_log.size(), 6);
        if (res_log.size() == 6)
            for (int i = 0; i < 6; i++) check("s3_result", res_log[i], s3_exp[i]);

        // 4. push and pop on the same edge at count = DEPTH-1
        @(posedge clk); #1;
        res_ready = 1'b0;
        res_log.delete();
        push_main(10, 1); push_main(20, 2); push_main(30, 3); push_main(40, 4);
        wait_valid("s4_wait_valid");
        @(posedge clk); #1; res_ready = 1'b1;
        @(posedge clk); #1; in_valid = 1'b1; in_a = 8'd50; in_b = 8'd5;
        @(posedge clk); #1; in_a = 8'd60; in_b = 8'd6;
        check("s4_count_unchanged", in_ready, 1);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        check("s4_full_after_extra", in_ready, 0);
        wait_idle("s4_drain");
        check("s4_count", res_log.size(), 6);
        if (res_log.size() == 6)
            for (int i = 0; i < 6; i++) check("s4_result", res_log[i], s4_exp[i]);
        log_en = 1'b0;

        // 5. reset during DRIVE with two pairs queued
        @(posedge clk); #1;
        res_ready = 1'b0;
        push_main(1, 1); push_main(2, 2); push_main(3, 3); push_main(4, 4);
        wait_valid("s5_wait_valid");
        @(posedge clk); #1; res_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        check("s5_in_drive", ui_in, 2);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("s5_ui_in_zero",  ui_in,      0);
        check("s5_fifo_empty",  busy,       0);
        check("s5_in_ready",    in_ready,   1);
        check("s5_done_reset",  done_count, 0);
        repeat (10) begin
            @(negedge clk);
            check("s5_no_result", res_valid, 0);
        end

        // 6. LAT=3 instance: one wrapping sum, then done_count wrap
        @(posedge clk); #1;
        push3(200, 100);
        n = 0; t = 0;
        do begin
            @(negedge clk);
            if (ui_in3 == 8'd200 && uio_in3 == 8'd100) n++;
            t++;
        end while (!res_valid3 && t < 30);
        check("s6_res_valid",    res_valid3, 1);
        check("s6_drive_cycles", n,          3);
        check("s6_res_data",     res_data3,  44);
        check("s6_res_a",        res_a3,     200);
        check("s6_res_b",        res_b3,     100);
        @(posedge clk); #1;
        for (int i = 1; i < 256; i++) push3(8'(i), 8'(i * 3));
        t = 0;
        while (hs3 < 255 && t < 3000) begin @(negedge clk); t++; end
        check("s6_done_255", done_count3, 255);
        t = 0;
        while (hs3 < 256 && t < 100) begin @(negedge clk); t++; end
        check("s6_done_wrap", done_count3, 0);
        check("s6_hs_total",  hs3,         256);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", ncyc);
        $fatal(1, "time limit");
    end

endmodule
